// File: rtl/d_flip_flop.sv
// d_flip_flop: positive-edge D-type register pipeline with asynchronous
// active-low reset and a clock enable shared by all stages.
// With the default parameters it is a plain single-bit D flip-flop:
// q follows d one clock edge later.
module d_flip_flop #(
   parameter int               WIDTH     = 1,   // data width of d and q
   parameter int               STAGES    = 1,   // d-to-q latency in clock edges
   parameter logic [WIDTH-1:0] RESET_VAL = '0   // value of every stage in reset
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // One entry per pipeline stage; stage[0] is nearest to d.
   logic [WIDTH-1:0] stage [STAGES];

   // Shift the pipeline on enabled edges; hold every stage when en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: every stage is reset, not just the output one, so data that
         // was in flight when reset hit can never reappear on q afterwards.
         for (int i = 0; i < STAGES; i++) begin
            stage[i] <= RESET_VAL;
         end
      end else if (en) begin
         // NOTE: non-blocking assignments make every stage read the value its
         // predecessor held before this edge, giving a true shift by one.
         stage[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   // The output is the last stage directly; no logic after the registers.
   assign q = stage[STAGES-1];

endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: checks a default (1-bit, 1-stage) instance and an 8-bit,
// 3-stage instance with reset value 8'hA5 against a history-based model:
// q equals the d captured STAGES enabled edges ago since the last reset,
// or the reset value when fewer enabled edges have happened.
module tb_d_flip_flop;

   localparam int            P_STAGES = 3;
   localparam logic [7:0]    P_RST    = 8'hA5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       d1;
   logic [7:0] d8;
   logic       q1;
   logic [7:0] q8;

   int n_checks = 0;
   int n_pass   = 0;
   bit checking = 1'b0;

   d_flip_flop u_dff (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     (d1),
      .q     (q1)
   );

   d_flip_flop #(
      .WIDTH     (8),
      .STAGES    (P_STAGES),
      .RESET_VAL (P_RST)
   ) u_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     (d8),
      .q     (q8)
   );

   always #5 clk = ~clk;

   // Reference model: values captured on enabled edges since the last reset.
   logic       hist1 [$];
   logic [7:0] hist8 [$];

   always @(posedge clk) begin
      if (rst_n === 1'b1 && en === 1'b1) begin
         hist1.push_back(d1);
         hist8.push_back(d8);
         if (hist1.size() > 1) void'(hist1.pop_front());
         if (hist8.size() > P_STAGES) void'(hist8.pop_front());
      end
   end

   always @(negedge rst_n) begin
      hist1.delete();
      hist8.delete();
   end

   function automatic logic [7:0] exp1();
      return (hist1.size() >= 1) ? {7'b0, hist1[0]} : 8'h00;
   endfunction

   function automatic logic [7:0] exp8();
      return (hist8.size() >= P_STAGES) ? hist8[0] : P_RST;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // Continuous comparison against the model, mid-cycle on every falling edge.
   always @(negedge clk) begin
      if (checking) begin
         check("model_q1", {7'b0, q1}, exp1());
         check("model_q8", q8, exp8());
      end
   end

   // Advance to 2ns after the next rising edge, where inputs are changed.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   logic prev;

   initial begin
      rst_n = 1'b1;
      en    = 1'b1;
      d1    = 1'b1;
      d8    = 8'h00;

      // Reset asserted mid-cycle takes effect immediately and holds.
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("reset_immediate_q1", {7'b0, q1}, 8'h00);
      check("reset_immediate_q8", q8, 8'hA5);
      checking = 1'b1;
      tick();
      tick();
      check("reset_hold_q1", {7'b0, q1}, 8'h00);
      check("reset_hold_q8", q8, 8'hA5);

      // Basic capture on the default instance.
      rst_n = 1'b1;
      d1    = 1'b0;
      tick();
      tick();
      check("capture_zero", {7'b0, q1}, 8'h00);
      d1 = 1'b1;
      #2;
      check("no_early_change", {7'b0, q1}, 8'h00);
      tick();
      check("capture_one", {7'b0, q1}, 8'h01);
      d1 = 1'b0;
      tick();
      check("capture_back_zero", {7'b0, q1}, 8'h00);

      // Pipeline latency on the 3-stage instance.
      d8 = 8'h01; tick();
      d8 = 8'h02; tick();
      d8 = 8'h03; tick();
      check("pipe_first", q8, 8'h01);
      tick();
      check("pipe_second", q8, 8'h02);
      tick();
      check("pipe_third", q8, 8'h03);

      // Fast toggle: q follows the previous edge's d and is stable between edges.
      for (int i = 0; i < 5; i++) begin
         prev = d1;
         d1   = ~d1;
         tick();
         check("toggle_after_edge", {7'b0, q1}, {7'b0, ~prev});
         #4;
         check("toggle_stable", {7'b0, q1}, {7'b0, ~prev});
         #1;
      end

      // Enable hold.
      d1 = 1'b1;
      tick();
      check("hold_setup", {7'b0, q1}, 8'h01);
      en = 1'b0;
      d1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_q1", {7'b0, q1}, 8'h01);
      end
      en = 1'b1;
      tick();
      check("hold_release", {7'b0, q1}, 8'h00);

      // Reset pulse between edges with data in flight.
      d8 = 8'h11; tick();
      d8 = 8'h22; tick();
      rst_n = 1'b0;
      #1;
      check("midop_reset", q8, 8'hA5);
      #2;
      rst_n = 1'b1;
      d8 = 8'h44;
      tick();
      check("midop_edge1", q8, 8'hA5);
      d8 = 8'h55;
      tick();
      check("midop_edge2", q8, 8'hA5);
      tick();
      check("midop_edge3", q8, 8'h44);

      // Reset asserted at the same instant as a rising edge: reset wins.
      d1 = 1'b1;
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      check("simul_reset_q1", {7'b0, q1}, 8'h00);
      check("simul_reset_q8", q8, 8'hA5);
      #2;
      rst_n = 1'b1;

      // Randomized traffic with occasional enable drops and reset pulses.
      for (int i = 0; i < 300; i++) begin
         tick();
         d1 = 1'($urandom);
         d8 = 8'($urandom);
         en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
         end
      end

      tick();
      checking = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
